// File: rtl/riscv32s_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | riscv32s_pkg : RAM geometry and dump-unit state encoding shared with RAM  |
// | Revision     : 1.0                                                        |
// +--------------------------------------------------------------------------+
package riscv32s_pkg;

  localparam int c_ram_depth      = 1024;
  localparam int c_data_width     = 32;
  localparam int c_checksum_width = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    SEND = 3'd3,
    DONE = 3'd4
  } dump_state_t;

  // Address width for a given depth; a single-word RAM still needs one bit.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_dump_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ram_dump_unit : walks the data RAM and streams every word with its index  |
// |                 over valid/ready, accumulating a 32-bit checksum          |
// | Revision      : 1.0                                                       |
// +--------------------------------------------------------------------------+
module ram_dump_unit
  import riscv32s_pkg::*;
#(
  parameter int RAMDEPTH  = c_ram_depth,
  parameter int ADDRWIDTH = addr_width(RAMDEPTH),
  parameter int DATAWIDTH = c_data_width
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        ram_ren,
  output logic [ADDRWIDTH-1:0]        ram_addr,
  input  logic [DATAWIDTH-1:0]        ram_rdata,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATAWIDTH-1:0]        out_data,
  output logic [ADDRWIDTH-1:0]        out_index,
  output logic                        out_last,
  output logic [c_checksum_width-1:0] checksum
);

  localparam logic [ADDRWIDTH-1:0] c_last_addr = ADDRWIDTH'(RAMDEPTH - 1);

  dump_state_t                 r_state;
  logic [ADDRWIDTH-1:0]        r_count;
  logic                        r_busy;
  logic                        r_done;
  logic                        r_ram_ren;
  logic [ADDRWIDTH-1:0]        r_ram_addr;
  logic                        r_out_valid;
  logic [DATAWIDTH-1:0]        r_out_data;
  logic [ADDRWIDTH-1:0]        r_out_index;
  logic                        r_out_last;
  logic [c_checksum_width-1:0] r_checksum;

  logic [ADDRWIDTH-1:0]        w_count_next;
  logic [c_checksum_width-1:0] w_data_ext;
  logic                        w_is_last;

  assign w_count_next = r_count + ADDRWIDTH'(1);
  assign w_is_last    = (r_count == c_last_addr);

  // Fit the RAM word to the checksum width before accumulating.
  generate
    if (DATAWIDTH >= c_checksum_width) begin : g_trunc
      assign w_data_ext = r_out_data[c_checksum_width-1:0];
    end else begin : g_zext
      assign w_data_ext = {{(c_checksum_width - DATAWIDTH){1'b0}}, r_out_data};
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ram_ren   <= 1'b0;
      r_ram_addr  <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_index <= '0;
      r_out_last  <= 1'b0;
      r_checksum  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state    <= REQ;
            r_count    <= '0;
            r_ram_addr <= '0;
            r_ram_ren  <= 1'b1;
            r_busy     <= 1'b1;
            r_checksum <= '0;
          end
        end
        REQ: begin
          r_ram_ren <= 1'b0;
          r_state   <= WAIT;
        end
        WAIT: begin
          r_out_data  <= ram_rdata;
          r_out_index <= r_count;
          r_out_last  <= w_is_last;
          r_out_valid <= 1'b1;
          r_state     <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            r_checksum  <= r_checksum + w_data_ext;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            if (w_is_last) begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_count    <= w_count_next;
              r_ram_addr <= w_count_next;
              r_ram_ren  <= 1'b1;
              r_state    <= REQ;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign ram_ren   = r_ram_ren;
  assign ram_addr  = r_ram_addr;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_index = r_out_index;
  assign out_last  = r_out_last;
  assign checksum  = r_checksum;

endmodule
`default_nettype wire
